// File: rtl/fifo_pkg.sv
// Shared types for the FIFO reader: skid-buffer occupancy states and default stream width.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // The state encoding doubles as the buffered word count.
    function automatic logic [1:0] occ_of(skid_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus outgoing valid/ready stream; master = reader, slave = FIFO and downstream.
interface fifo_reader_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_underflow;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [15:0]           rd_count;
    logic                  err_underflow;

    modport master (
        input  enable, fifo_empty, fifo_data, fifo_underflow, m_ready,
        output fifo_rd_en, m_valid, m_data, rd_count, err_underflow
    );

    modport slave (
        output enable, fifo_empty, fifo_data, fifo_underflow, m_ready,
        input  fifo_rd_en, m_valid, m_data, rd_count, err_underflow
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer; a pushed word is visible the next cycle.
// Head stays put while valid and not popped; caller must never push when full.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] dat
);
    skid_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  vld_q, vld_d;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = push_dat;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = push_dat;
                end else if (push) begin
                    tail_d  = push_dat;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        vld_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            vld_q   <= vld_d;
        end
    end

    assign occ = occ_of(state_q);
    assign vld = vld_q;
    assign dat = head_q;
endmodule

// File: rtl/fifo_reader.sv
// Drains a FIFO into a valid/ready stream: 2 cycles from rd_en to m_valid, then 1 word/cycle.
// Reads are throttled so buffered plus in-flight words never exceed the 2-entry skid buffer.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input logic           clk,
    input logic           rst,
    fifo_reader_if.master bus
);
    logic [1:0]            occ;
    logic                  pop;
    logic                  push;
    logic                  rd_en;
    logic [2:0]            load;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  inflight_q, inflight_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic                  err_underflow_q, err_underflow_d;

    assign pop  = m_valid && bus.m_ready;
    assign push = inflight_q;

    // A pop this cycle frees a slot in time for a read issued now.
    always_comb begin
        load            = {1'b0, occ} + {2'b00, inflight_q};
        rd_en           = bus.enable && !bus.fifo_empty && !rst
                          && (load < (3'd2 + {2'b00, pop}));
        inflight_d      = rd_en;
        rd_count_d      = rd_count_q + {15'd0, pop};
        err_underflow_d = err_underflow_q || bus.fifo_underflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q      <= 1'b0;
            rd_count_q      <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            inflight_q      <= inflight_d;
            rd_count_q      <= rd_count_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (bus.fifo_data),
        .pop      (pop),
        .occ      (occ),
        .vld      (m_valid),
        .dat      (m_data)
    );

    assign bus.fifo_rd_en    = rd_en;
    assign bus.m_valid       = m_valid;
    assign bus.m_data        = m_data;
    assign bus.rd_count      = rd_count_q;
    assign bus.err_underflow = err_underflow_q;
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 16, width of FIFO and stream data.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 enable  input  1  permits new FIFO reads when high.
REQ-006 fifo_empty  input  1  FIFO empty flag, combinational from the FIFO count.
REQ-007 fifo_data  input  DATA_WIDTH  FIFO read data, valid on the cycle after rd_en.
REQ-008 fifo_underflow  input  1  FIFO underflow flag, registered.
REQ-009 fifo_rd_en  output  1  read strobe to the FIFO.
REQ-010 m_valid  output  1  stream word available.
REQ-011 m_ready  input  1  downstream accepts the word.
REQ-012 m_data  output  DATA_WIDTH  stream word.
REQ-013 rd_count  output  16  count of words delivered on the stream.
REQ-014 err_underflow  output  1  sticky underflow error.

Function
REQ-015 A read issued in cycle N SHALL capture fifo_data at the rising edge ending cycle N+1, with one read in flight at most.
REQ-016 Output buffering SHALL be a 2-entry skid buffer, occ in 0..2, with states EMPTY, ONE and TWO.
REQ-017 pop SHALL equal m_valid && m_ready. The stream transfer SHALL happen in the same cycle.
REQ-018 fifo_rd_en SHALL be combinational and asserted iff enable && !fifo_empty && !rst && (occ + inflight - pop) < 2.
REQ-019 fifo_rd_en SHALL never assert while fifo_empty is high.
REQ-020 inflight SHALL be set on the cycle after fifo_rd_en and cleared on the cycle after that unless a new read is issued.
REQ-021 State transitions SHALL follow push = inflight capture and pop as defined above:
- EMPTY to ONE on push.
- ONE to TWO on push && !pop.
- ONE to EMPTY on pop && !push.
- TWO to ONE on pop.
- All other cases hold state.
REQ-022 push and pop in the same cycle in state ONE SHALL keep the state at ONE.
REQ-023 A push in state TWO is impossible by REQ-018; the bench SHALL flag it as an error.
REQ-024 m_valid SHALL equal (occ != 0).
REQ-025 m_data SHALL be the oldest buffered word and SHALL stay stable while m_valid && !m_ready.
REQ-026 With enable=1, m_ready=1 and the FIFO continuously non-empty, throughput SHALL be 1 word/cycle after a 2-cycle initial latency from rd_en to m_valid.
REQ-027 Words SHALL be delivered in FIFO order with none dropped or duplicated.
REQ-028 rd_count SHALL increment by 1 on each pop and wrap from 0xFFFF to 0x0000.
REQ-029 err_underflow SHALL set on the cycle after fifo_underflow is seen high and hold until rst.
REQ-030 Deasserting enable SHALL stop new reads only; in-flight and buffered words SHALL still be delivered.

Reset
REQ-031 While rst is high, the following SHALL be 0: fifo_rd_en, m_valid, rd_count, err_underflow, occ (EMPTY) and inflight.
REQ-032 The reset value of m_data SHALL be all zeros.
REQ-033 Reset mid-operation SHALL discard buffered words and any in-flight read return.
REQ-034 The integrator SHALL reset the FIFO in the same cycle.

Structure
REQ-035 The skid buffer state enum {EMPTY, ONE, TWO} and the default DATA_WIDTH SHALL live in shared package fifo_pkg.
REQ-036 The 2-entry buffer SHALL be a sub-module, fifo_skid_buf, with push/pop/occ ports.
REQ-037 Read-issue logic and counters SHALL be in fifo_reader.

Verification
REQ-038 Reset: rst=1 for 2 cycles with the FIFO holding 3 words -> all outputs 0 and fifo_rd_en=0; after rst falls, first m_valid appears 2 cycles later.
REQ-039 Streaming: write 0x0001..0x0008, enable=1, m_ready=1 -> m_data 0x0001..0x0008 on 8 consecutive cycles; rd_count=8; fifo_rd_en never high while fifo_empty=1.
REQ-040 Backpressure: m_ready=0 for 5 cycles with the FIFO holding 6 words -> exactly 2 reads issued, occ=TWO, m_data=0x0001 held stable; on release, 6 words in order with no gaps.
REQ-041 Simultaneous push/pop: m_ready toggling 1,0,1,0 with 8 words -> order preserved, occ never exceeds 2, no loss.
REQ-042 Error/wrap: preload rd_count to 0xFFFE via 2 pops after a forced start, then 2 more pops -> rd_count=0x0000. A fifo_underflow pulse -> err_underflow=1 until rst.
REQ-043 Reset mid-operation: rst asserted the cycle after fifo_rd_en -> the returned word is not delivered and m_valid=0 on the cycle after rst.
